// File: rtl/mem_bus_arbiter.sv
// Two-master (fetch/data) arbiter onto a single-outstanding memory bus, with
// starvation protection for fetch, fetch flush/drop and a BUSY timeout abort.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        if_gnt_q, if_gnt_d;
  logic        d_gnt_q, d_gnt_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        bus_err_q, bus_err_d;
  logic [2:0]  starve_q, starve_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        drop_q, drop_d;

  logic        done;
  logic        timed_out;
  logic [31:0] ret_data;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    bus_err_d   = 1'b0;
    starve_d    = if_req ? starve_q : 3'd0;
    tmo_d       = tmo_q;
    drop_d      = drop_q;
    timed_out   = !mem_ack && (tmo_q == TMO_LAST);
    done        = mem_ack || timed_out;
    ret_data    = mem_ack ? mem_rdata : 32'd0;

    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (d_req && !(if_req && (starve_q == STARVE_MAX))) begin
          state_d = BUSY_D;
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
          wstrb_d = d_wstrb;
          d_gnt_d = 1'b1;
          tmo_d   = 8'd0;
          if (if_req) starve_d = starve_q + 3'd1;
        end else if (if_req) begin
          state_d  = BUSY_I;
          addr_d   = if_addr;
          we_d     = 1'b0;
          wdata_d  = 32'd0;
          wstrb_d  = 4'd0;
          if_gnt_d = 1'b1;
          tmo_d    = 8'd0;
          starve_d = 3'd0;
        end
      end
      BUSY_I: begin
        if (if_flush) drop_d = 1'b1;
        if (done) begin
          state_d   = IDLE;
          drop_d    = 1'b0;
          bus_err_d = timed_out;
          // A flush on the completing cycle still counts as discarding the fetch.
          if (!(drop_q || if_flush)) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = ret_data;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      BUSY_D: begin
        if (done) begin
          state_d    = IDLE;
          d_rvalid_d = 1'b1;
          bus_err_d  = timed_out;
          if (!we_q || timed_out) d_rdata_d = ret_data;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= 32'd0;
      we_q        <= 1'b0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
      bus_err_q   <= 1'b0;
      starve_q    <= 3'd0;
      tmo_q       <= 8'd0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      bus_err_q   <= bus_err_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      drop_q      <= drop_d;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: each task drives one scenario cycle by
// cycle and compares the DUT outputs against hand-computed values.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        bus_err;

  int checks = 0;
  int fails  = 0;

  mem_bus_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Each step lands 1 time unit after a rising edge, i.e. inside the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (mem_req !== 1'b0) begin fails++; $display("[TB] FAIL rst_mem_req: got %0b want 0", mem_req); end
    step(); step();
    checks++; if ({if_gnt, d_gnt, if_rvalid, d_rvalid, bus_err} !== 5'b0) begin fails++; $display("[TB] FAIL rst_pulses: got %b want 00000", {if_gnt, d_gnt, if_rvalid, d_rvalid, bus_err}); end
    checks++; if ({if_rdata, d_rdata} !== 64'd0) begin fails++; $display("[TB] FAIL rst_rdata: got %h/%h want 0/0", if_rdata, d_rdata); end
    checks++; if ({mem_addr, mem_wdata, mem_wstrb, mem_we} !== 69'd0) begin fails++; $display("[TB] FAIL rst_latches: addr %h wdata %h strb %h we %b want 0", mem_addr, mem_wdata, mem_wstrb, mem_we); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h100;
    step();
    checks++; if (if_gnt !== 1'b1 || mem_req !== 1'b1) begin fails++; $display("[TB] FAIL fetch_gnt: gnt %b req %b want 1 1", if_gnt, mem_req); end
    checks++; if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin fails++; $display("[TB] FAIL fetch_addr: got %h we %b want 00000100 0", mem_addr, mem_we); end
    if_req = 1'b0;
    step();
    checks++; if (if_gnt !== 1'b0 || mem_req !== 1'b1) begin fails++; $display("[TB] FAIL fetch_busy: gnt %b req %b want 0 1", if_gnt, mem_req); end
    step();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_ack = 1'b0;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL fetch_rvalid: rvalid %b data %h want 1 deadbeef", if_rvalid, if_rdata); end
    checks++; if (mem_req !== 1'b0 || bus_err !== 1'b0) begin fails++; $display("[TB] FAIL fetch_done: req %b err %b want 0 0", mem_req, bus_err); end
    step();
    checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL fetch_hold: rvalid %b data %h want 0 deadbeef", if_rvalid, if_rdata); end
  endtask

  task automatic test_data_read_write();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
    step();
    checks++; if (d_gnt !== 1'b1 || mem_addr !== 32'h3000 || mem_we !== 1'b0) begin fails++; $display("[TB] FAIL dread_gnt: gnt %b addr %h we %b want 1 00003000 0", d_gnt, mem_addr, mem_we); end
    d_req = 1'b0; d_addr = 32'hFFFFFFFF;
    step();
    checks++; if (mem_addr !== 32'h3000) begin fails++; $display("[TB] FAIL dread_latch: got %h want 00003000", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_ack = 1'b0;
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hCAFEF00D) begin fails++; $display("[TB] FAIL dread_rvalid: rvalid %b data %h want 1 cafef00d", d_rvalid, d_rdata); end
    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wstrb = 4'h3; d_wdata = 32'h1234;
    step();
    checks++; if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wstrb !== 4'h3) begin fails++; $display("[TB] FAIL write_ctl: gnt %b we %b strb %h want 1 1 3", d_gnt, mem_we, mem_wstrb); end
    checks++; if (mem_addr !== 32'h2000 || mem_wdata !== 32'h1234) begin fails++; $display("[TB] FAIL write_opnd: addr %h wdata %h want 00002000 00001234", mem_addr, mem_wdata); end
    d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h55555555;
    step();
    mem_ack = 1'b0;
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hCAFEF00D) begin fails++; $display("[TB] FAIL write_done: rvalid %b data %h want 1 cafef00d", d_rvalid, d_rdata); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_is_fetch;
    logic [9:0] got_is_fetch;
    int n, first, last;
    exp_is_fetch = 10'b1000010000;
    got_is_fetch = 10'd0;
    n = 0; first = -1; last = -1;
    if_req = 1'b1; if_addr = 32'hB0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'hA0;
    mem_ack = 1'b1; mem_rdata = 32'h0BB00BB0;
    for (int c = 0; c < 40 && n < 10; c++) begin
      step();
      if (if_gnt || d_gnt) begin
        checks++; if (if_gnt && d_gnt) begin fails++; $display("[TB] FAIL b2b_exclusive: both grants at grant %0d", n); end
        got_is_fetch[n] = if_gnt;
        if (n == 0) first = c;
        last = c;
        n++;
      end
    end
    checks++; if (n != 10) begin fails++; $display("[TB] FAIL b2b_count: got %0d grants want 10", n); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (got_is_fetch[i] !== exp_is_fetch[i]) begin fails++; $display("[TB] FAIL b2b_order[%0d]: got %s want %s", i, got_is_fetch[i] ? "I" : "D", exp_is_fetch[i] ? "I" : "D"); end
    end
    checks++; if (last - first != 18) begin fails++; $display("[TB] FAIL b2b_rate: span %0d cycles want 18", last - first); end
    if_req = 1'b0; d_req = 1'b0;
    step(); step(); step();
    mem_ack = 1'b0;
    step();
  endtask

  task automatic test_flush();
    if_req = 1'b1; if_addr = 32'h400;
    step();
    checks++; if (if_gnt !== 1'b1) begin fails++; $display("[TB] FAIL flush_gnt: got %b want 1", if_gnt); end
    if_req = 1'b0; if_flush = 1'b1;
    step();
    if_flush = 1'b0;
    step();
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    step();
    mem_ack = 1'b0;
    checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0BB00BB0) begin fails++; $display("[TB] FAIL flush_drop: rvalid %b data %h want 0 0bb00bb0", if_rvalid, if_rdata); end
    checks++; if (mem_req !== 1'b0) begin fails++; $display("[TB] FAIL flush_idle: mem_req %b want 0", mem_req); end
    step();
    checks++; if (d_gnt !== 1'b1 || mem_addr !== 32'h500) begin fails++; $display("[TB] FAIL flush_next_gnt: gnt %b addr %h want 1 00000500", d_gnt, mem_addr); end
    d_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555AAAA;
    step();
    mem_ack = 1'b0;
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h5555AAAA) begin fails++; $display("[TB] FAIL flush_next_done: rvalid %b data %h want 1 5555aaaa", d_rvalid, d_rdata); end
    step();
    // Flush coincident with the ack cycle.
    if_req = 1'b1; if_addr = 32'h440;
    step();
    if_req = 1'b0; if_flush = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h33333333;
    step();
    mem_ack = 1'b0; if_flush = 1'b0;
    checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0BB00BB0) begin fails++; $display("[TB] FAIL flush_ack_cycle: rvalid %b data %h want 0 0bb00bb0", if_rvalid, if_rdata); end
    // Flush while IDLE is ignored, and the drop flag must not linger.
    if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h480;
    step();
    checks++; if (if_gnt !== 1'b1 || mem_addr !== 32'h480) begin fails++; $display("[TB] FAIL flush_idle_gnt: gnt %b addr %h want 1 00000480", if_gnt, mem_addr); end
    if_req = 1'b0; if_flush = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h22222222;
    step();
    mem_ack = 1'b0;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h22222222) begin fails++; $display("[TB] FAIL flush_idle_rvalid: rvalid %b data %h want 1 22222222", if_rvalid, if_rdata); end
    step();
  endtask

  task automatic test_timeout();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    step();
    d_req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      checks++; if (mem_req !== 1'b1 || bus_err !== 1'b0) begin fails++; $display("[TB] FAIL tmo_busy[%0d]: req %b err %b want 1 0", k, mem_req, bus_err); end
      step();
    end
    checks++; if (mem_req !== 1'b0 || d_rvalid !== 1'b1 || bus_err !== 1'b1) begin fails++; $display("[TB] FAIL tmo_abort: req %b rvalid %b err %b want 0 1 1", mem_req, d_rvalid, bus_err); end
    checks++; if (d_rdata !== 32'd0) begin fails++; $display("[TB] FAIL tmo_rdata: got %h want 0", d_rdata); end
    step();
    checks++; if (bus_err !== 1'b0 || d_rvalid !== 1'b0) begin fails++; $display("[TB] FAIL tmo_pulse: err %b rvalid %b want 0 0", bus_err, d_rvalid); end
    if_req = 1'b1; if_addr = 32'h900;
    step();
    if_req = 1'b0;
    for (int k = 0; k < 8; k++) step();
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'd0 || bus_err !== 1'b1) begin fails++; $display("[TB] FAIL tmo_fetch: rvalid %b data %h err %b want 1 0 1", if_rvalid, if_rdata, bus_err); end
    step();
    // An ack on the last allowed BUSY cycle completes normally.
    d_req = 1'b1; d_addr = 32'hA00;
    step();
    d_req = 1'b0;
    for (int k = 0; k < 7; k++) step();
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    step();
    mem_ack = 1'b0;
    checks++; if (d_rvalid !== 1'b1 || bus_err !== 1'b0 || d_rdata !== 32'h77777777) begin fails++; $display("[TB] FAIL tmo_last_ack: rvalid %b err %b data %h want 1 0 77777777", d_rvalid, bus_err, d_rdata); end
    step();
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
    step();
    checks++; if (d_gnt !== 1'b1) begin fails++; $display("[TB] FAIL rmid_gnt: got %b want 1", d_gnt); end
    d_req = 1'b0;
    step();
    rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || d_rdata !== 32'd0) begin fails++; $display("[TB] FAIL rmid_async: req %b data %h want 0 0", mem_req, d_rdata); end
    mem_ack = 1'b1;
    step();
    checks++; if (d_rvalid !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("[TB] FAIL rmid_no_rvalid: rvalid %b req %b want 0 0", d_rvalid, mem_req); end
    rst = 1'b0; mem_ack = 1'b0;
    d_req = 1'b1; d_addr = 32'h800;
    step();
    checks++; if (d_gnt !== 1'b1 || mem_addr !== 32'h800) begin fails++; $display("[TB] FAIL rmid_regrant: gnt %b addr %h want 1 00000800", d_gnt, mem_addr); end
    d_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h88888888;
    step();
    mem_ack = 1'b0;
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h88888888) begin fails++; $display("[TB] FAIL rmid_done: rvalid %b data %h want 1 88888888", d_rvalid, d_rdata); end
    step();
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_flush = 1'b0; if_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_wstrb = 4'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    test_reset();
    test_fetch();
    test_data_read_write();
    test_back_to_back();
    test_flush();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
